serial_slice_adder: RTL

SERIAL_SLICE_ADDER -- requirements
Module: serial_slice_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/rca_4bit.sv | 21 ++
 rtl/serial_slice_adder.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial slice adder: FSM state encoding and slice width.
package serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder slice: {Cout,Sum} = A + B + Cin.
module rca_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign Sum[i]       = A[i] ^ B[i] ^ w_carry[i];
    assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_carry[4];

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle adder that sums WIDTH-bit operands one 4-bit slice per clock, LSB slice first,
// through a single shared ripple-carry slice.
module serial_slice_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [IDX_W+1:0]   w_base;
  logic [SLICE_W-1:0] w_sliceA;
  logic [SLICE_W-1:0] w_sliceB;
  logic [SLICE_W-1:0] w_sliceSum;
  logic               w_sliceCout;

  // Bit offset of the current slice (idx * 4).
  assign w_base   = {r_idx, 2'b00};
  assign w_sliceA = r_a[w_base +: SLICE_W];
  assign w_sliceB = r_b[w_base +: SLICE_W];

  rca_4bit u_slice (
    .A    (w_sliceA),
    .B    (w_sliceB),
    .Cin  (r_carry),
    .Sum  (w_sliceSum),
    .Cout (w_sliceCout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_res[w_base +: SLICE_W] <= w_sliceSum;
          r_carry <= w_sliceCout;
          r_idx   <= r_idx + IDX_W'(1);
          // The last slice is the top one, so the finished result merges it in directly.
          if (r_idx == LAST_IDX) begin
            Sum     <= {w_sliceSum, r_res[WIDTH-SLICE_W-1:0]};
            Cout    <= w_sliceCout;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
